// File: rtl/cpu_datapath_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the cpu_datapath register-file/ALU slice:
//   alu_op_t     ALU opcode encoding (codes 8..15 are reserved, result 0)
//   SEL_W        opcode field width
//   MUX_EXT_BIT  mux_sel bit that routes d_in onto the bus
//   NUM_REGS     number of general registers R0..R7
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam int SEL_W       = 4;
  localparam int MUX_EXT_BIT = 3;
  localparam int NUM_REGS    = 8;

  typedef enum logic [SEL_W-1:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SHL    = 4'd5,
    ALU_SHR    = 4'd6,
    ALU_PASS_B = 4'd7
  } alu_op_t;

  // Only the lower half of the opcode space is populated; the upper half
  // is reserved and must produce a zero result with no carry.
  function automatic logic op_is_defined(input logic [SEL_W-1:0] op);
    return (op[SEL_W-1] == 1'b0);
  endfunction

endpackage

// File: rtl/cpu_datapath_alu.sv
// ----------------------------------------------------------------------------
// alu
// Combinational ALU for cpu_datapath. Result wraps mod 2^WIDTH.
// Ports:
//   a      in  WIDTH  operand A (register S)
//   b      in  WIDTH  operand B (bus)
//   sel    in  4      opcode (see cpu_pkg::alu_op_t)
//   y      out WIDTH  result
//   carry  out 1      carry-out (ADD), NOT borrow (SUB), last bit shifted
//                     out (SHL/SHR), 0 otherwise
// Shift amount is b[3:0], so WIDTH must be at least 4.
// ----------------------------------------------------------------------------
module alu
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] y,
  output logic             carry
);

  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [2*WIDTH-1:0] shl_ext;
  logic [2*WIDTH-1:0] shr_ext;
  logic [3:0]         shamt;

  assign shamt    = b[3:0];
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  // Bit WIDTH of the extended difference is the borrow.
  assign diff_ext = {1'b0, a} - {1'b0, b};
  // Shifting inside a double-width window keeps the bit that fell off the
  // end at a fixed position (WIDTH for SHL, WIDTH-1 for SHR); with a zero
  // shift that position holds 0, so no special case is needed.
  assign shl_ext  = {{WIDTH{1'b0}}, a} << shamt;
  assign shr_ext  = {a, {WIDTH{1'b0}}} >> shamt;

  always_comb begin
    y     = '0;
    carry = 1'b0;
    if (op_is_defined(sel)) begin
      case (alu_op_t'(sel))
        ALU_ADD: begin
          y     = sum_ext[WIDTH-1:0];
          carry = sum_ext[WIDTH];
        end
        ALU_SUB: begin
          y     = diff_ext[WIDTH-1:0];
          carry = ~diff_ext[WIDTH];
        end
        ALU_AND: y = a & b;
        ALU_OR:  y = a | b;
        ALU_XOR: y = a ^ b;
        ALU_SHL: begin
          y     = shl_ext[WIDTH-1:0];
          carry = shl_ext[WIDTH];
        end
        ALU_SHR: begin
          y     = shr_ext[2*WIDTH-1:WIDTH];
          carry = shr_ext[WIDTH-1];
        end
        ALU_PASS_B: y = b;
        default: begin
          y     = '0;
          carry = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/cpu_datapath.sv
// ----------------------------------------------------------------------------
// cpu_datapath
// Register file (R0..R7), operand register S, result register C, bus mux and
// ALU sitting behind the cpu control FSM. Every enable acts independently on
// the same edge and always sees pre-edge register values.
// Ports:
//   clk           in  1      rising-edge clock
//   reset         in  1      asynchronous active-low reset
//   d_in          in  WIDTH  external operand (bus source when mux_sel[3]=1)
//   mux_sel       in  4      bus source: [3]=1 d_in, else R[mux_sel[2:0]]
//   sel           in  4      ALU opcode
//   en_s          in  1      S <- bus
//   en_c          in  1      C <- ALU(S, bus)
//   en            in  8      one-hot-ish register write enables, R[i] <- C
//   done          in  1      instruction-complete strobe
//   bus           out WIDTH  combinational bus value
//   result        out WIDTH  copy of the last C written into any R[i]
//   result_valid  out 1      pulse when a write-back coincides with done
//   flag_z/flag_c out 1      zero/carry flags, only with CPU_DP_FLAGS_EN
// Optional feature macro: CPU_DP_FLAGS_EN (adds flag_z/flag_c).
// ----------------------------------------------------------------------------
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  input  logic [3:0]       mux_sel,
  input  logic [SEL_W-1:0] sel,
  input  logic             en_s,
  input  logic             en_c,
  input  logic [7:0]       en,
  input  logic             done,
  output logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
`ifdef CPU_DP_FLAGS_EN
  ,
  output logic             flag_z,
  output logic             flag_c
`endif
);

  logic [WIDTH-1:0] r_q [NUM_REGS];
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] alu_y;

`ifdef CPU_DP_FLAGS_EN
  logic alu_carry;
`else
  logic unused_alu_carry;
`endif

  // Bus: pure mux, nothing else may drive it.
  always_comb begin
    bus = d_in;
    if (!mux_sel[MUX_EXT_BIT]) begin
      bus = r_q[mux_sel[2:0]];
    end
  end

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a     (s_q),
    .b     (bus),
    .sel   (sel),
    .y     (alu_y),
`ifdef CPU_DP_FLAGS_EN
    .carry (alu_carry)
`else
    .carry (unused_alu_carry)
`endif
  );

  // Register stage: S, C and R[] all load from pre-edge values, so
  // en_s+en_c uses the old S and en_c+en[i] writes the old C.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q <= '0;
      c_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      if (en_s) begin
        s_q <= bus;
      end
      if (en_c) begin
        c_q <= alu_y;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        if (en[i]) begin
          r_q[i] <= c_q;
        end
      end
    end
  end

  // Result reporting: any write-back updates result; only a write-back
  // together with done raises the one-cycle valid pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      if (en != 8'h00) begin
        result <= c_q;
      end
      result_valid <= (en != 8'h00) && done;
    end
  end

`ifdef CPU_DP_FLAGS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (en_c) begin
      flag_z <= (alu_y == '0);
      flag_c <= alu_carry;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// ----------------------------------------------------------------------------
// tb_cpu_datapath
// Self-checking bench for cpu_datapath: directed scenarios from the datapath
// rules plus a randomized run against a behavioural model of R0..R7, S, C.
// ----------------------------------------------------------------------------
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] d_in = '0;
  logic [3:0]  mux_sel = '0;
  logic [3:0]  sel = '0;
  logic        en_s = 1'b0;
  logic        en_c = 1'b0;
  logic [7:0]  en = '0;
  logic        done = 1'b0;
  logic [15:0] bus;
  logic [15:0] result;
  logic        result_valid;
`ifdef CPU_DP_FLAGS_EN
  logic        flag_z;
  logic        flag_c;
`endif

  int total = 0;
  int bad = 0;

  // Behavioural model state
  logic [15:0] m_r [8];
  logic [15:0] m_s = '0;
  logic [15:0] m_c = '0;
  logic [15:0] m_result = '0;
  logic        m_rv = 1'b0;
  logic        m_fz = 1'b0;
  logic        m_fc = 1'b0;

  cpu_datapath #(.WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .d_in         (d_in),
    .mux_sel      (mux_sel),
    .sel          (sel),
    .en_s         (en_s),
    .en_c         (en_c),
    .en           (en),
    .done         (done),
    .bus          (bus),
    .result       (result),
    .result_valid (result_valid)
`ifdef CPU_DP_FLAGS_EN
    ,
    .flag_z       (flag_z),
    .flag_c       (flag_c)
`endif
  );

  always #5 clk = ~clk;

  // Reference ALU written with plain integer arithmetic.
  function automatic void alu_ref(input longint a, input longint b, input int op,
                                  output logic [15:0] y, output logic cy);
    longint full;
    longint sh;
    sh   = b % 16;
    y    = '0;
    cy   = 1'b0;
    full = 0;
    case (op)
      0: begin full = a + b; y = 16'(full % 65536); cy = (full >= 65536); end
      1: begin y = 16'((a - b + 65536) % 65536); cy = (a >= b); end
      2: y = 16'(a) & 16'(b);
      3: y = 16'(a) | 16'(b);
      4: y = 16'(a) ^ 16'(b);
      5: begin
        full = a * (longint'(1) << sh);
        y    = 16'(full % 65536);
        cy   = (sh != 0) && (((full / 65536) % 2) == 1);
      end
      6: begin
        y  = 16'(a / (longint'(1) << sh));
        cy = (sh != 0) && (((a / (longint'(1) << (sh - 1))) % 2) == 1);
      end
      7: y = 16'(b);
      default: begin y = '0; cy = 1'b0; end
    endcase
  endfunction

  function automatic logic [15:0] model_bus();
    if (mux_sel[3]) return d_in;
    return m_r[mux_sel[2:0]];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_s = '0; m_c = '0; m_result = '0; m_rv = 1'b0; m_fz = 1'b0; m_fc = 1'b0;
  endtask

  task automatic set_in(input logic [15:0] d, input logic [3:0] ms, input logic [3:0] sl,
                        input logic es, input logic ec, input logic [7:0] e, input logic dn);
    d_in = d; mux_sel = ms; sel = sl; en_s = es; en_c = ec; en = e; done = dn;
    #1;
  endtask

  // Advance one clock edge, updating the model from pre-edge values.
  task automatic tick();
    logic [15:0] b;
    logic [15:0] y;
    logic        cy;
    @(posedge clk);
    if (reset) begin
      b = model_bus();
      alu_ref(longint'(m_s), longint'(b), int'(sel), y, cy);
      for (int i = 0; i < 8; i++) if (en[i]) m_r[i] = m_c;
      if (en != 0) m_result = m_c;
      m_rv = (en != 0) && done;
      if (en_c) begin m_fz = (y == 0); m_fc = cy; end
      if (en_c) m_c = y;
      if (en_s) m_s = b;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_clear();
    d_in = 16'hFFFF; mux_sel = 4'hF; sel = 4'h0; en_s = 1; en_c = 1; en = 8'hFF; done = 1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (result !== 16'h0 || result_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: result=%h valid=%b required result=0000 valid=0", result, result_valid);
    end
    reset = 1'b1;
    set_in(16'h0, 4'h0, 4'h0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      set_in(16'h0, 4'(i), 4'h0, 0, 0, 8'h00, 0);
      total++;
      if (bus !== 16'h0) begin
        bad++;
        $display("FAIL reset_r%0d: bus=%h required 0000", i, bus);
      end
    end
    tick();
    total++;
    if (result !== 16'h0 || result_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: result=%h valid=%b required 0000/0", result, result_valid);
    end
    // C readout through R0
    set_in(16'h0, 4'h8, 4'h0, 0, 0, 8'h01, 0);
    tick();
    total++;
    if (result !== 16'h0) begin
      bad++;
      $display("FAIL reset_c: result=%h required 0000", result);
    end
    // S readout: ADD with bus=0 copies S into C
    set_in(16'h0, 4'h8, 4'h0, 0, 1, 8'h00, 0);
    tick();
    set_in(16'h0, 4'h8, 4'h0, 0, 0, 8'h01, 0);
    tick();
    total++;
    if (result !== 16'h0) begin
      bad++;
      $display("FAIL reset_s: result=%h required 0000", result);
    end
  endtask

  task automatic test_add_writeback();
    int pulses;
    set_in(16'd5, 4'h8, 4'h7, 1, 1, 8'h00, 0); tick();
    set_in(16'd7, 4'h8, 4'h7, 0, 1, 8'h02, 0); tick();
    set_in(16'd0, 4'h0, 4'h7, 0, 0, 8'h04, 0); tick();
    set_in(16'd0, 4'h1, 4'h0, 1, 0, 8'h00, 0);
    total++;
    if (bus !== 16'd5) begin
      bad++;
      $display("FAIL add_r1: bus=%0d required 5", bus);
    end
    tick();
    set_in(16'd0, 4'h2, 4'h0, 0, 1, 8'h00, 0);
    total++;
    if (bus !== 16'd7) begin
      bad++;
      $display("FAIL add_r2: bus=%0d required 7", bus);
    end
    tick();
    set_in(16'd0, 4'h0, 4'h0, 0, 0, 8'h08, 1); tick();
    pulses = int'(result_valid);
    total++;
    if (result !== 16'd12 || result_valid !== 1'b1) begin
      bad++;
      $display("FAIL add_result: result=%0d valid=%b required 12/1", result, result_valid);
    end
    set_in(16'd0, 4'h3, 4'h0, 0, 0, 8'h00, 0); tick();
    pulses += int'(result_valid);
    total++;
    if (bus !== 16'd12 || pulses != 1) begin
      bad++;
      $display("FAIL add_r3: bus=%0d pulses=%0d required 12/1", bus, pulses);
    end
  endtask

  task automatic test_wrap();
    set_in(16'hFFFF, 4'h8, 4'h0, 1, 0, 8'h00, 0); tick();
    set_in(16'h0001, 4'h8, 4'h0, 0, 1, 8'h00, 0); tick();
`ifdef CPU_DP_FLAGS_EN
    total++;
    if (flag_z !== 1'b1 || flag_c !== 1'b1) begin
      bad++;
      $display("FAIL wrap_flags: z=%b c=%b required 1/1", flag_z, flag_c);
    end
`endif
    set_in(16'h0, 4'h8, 4'h0, 0, 0, 8'h80, 0); tick();
    total++;
    if (result !== 16'h0000 || result_valid !== 1'b0) begin
      bad++;
      $display("FAIL wrap_add: result=%h valid=%b required 0000/0", result, result_valid);
    end
  endtask

  task automatic test_sub_underflow();
    set_in(16'd3, 4'h8, 4'h0, 1, 0, 8'h00, 0); tick();
    set_in(16'd5, 4'h8, 4'h1, 0, 1, 8'h00, 0); tick();
`ifdef CPU_DP_FLAGS_EN
    total++;
    if (flag_z !== 1'b0 || flag_c !== 1'b0) begin
      bad++;
      $display("FAIL sub_flags: z=%b c=%b required 0/0", flag_z, flag_c);
    end
`endif
    set_in(16'h0, 4'h8, 4'h0, 0, 0, 8'h40, 1); tick();
    total++;
    if (result !== 16'hFFFE || result_valid !== 1'b1) begin
      bad++;
      $display("FAIL sub_underflow: result=%h valid=%b required fffe/1", result, result_valid);
    end
  endtask

  task automatic test_simultaneous();
    set_in(16'd9, 4'h8, 4'h7, 0, 1, 8'h00, 0); tick();
    set_in(16'd2, 4'h8, 4'h0, 1, 0, 8'h00, 0); tick();
    set_in(16'd4, 4'h8, 4'h0, 1, 1, 8'hFF, 0); tick();
    total++;
    if (result !== 16'd9) begin
      bad++;
      $display("FAIL simul_result: result=%0d required 9", result);
    end
    for (int i = 0; i < 8; i++) begin
      set_in(16'h0, 4'(i), 4'h0, 0, 0, 8'h00, 0);
      total++;
      if (bus !== 16'd9) begin
        bad++;
        $display("FAIL simul_r%0d: bus=%0d required 9", i, bus);
      end
    end
    set_in(16'h0, 4'h8, 4'h0, 0, 0, 8'h01, 0); tick();
    total++;
    if (result !== 16'd6) begin
      bad++;
      $display("FAIL simul_c: result=%0d required 6", result);
    end
    set_in(16'h0, 4'h8, 4'h0, 0, 1, 8'h00, 0); tick();
    set_in(16'h0, 4'h8, 4'h0, 0, 0, 8'h01, 0); tick();
    total++;
    if (result !== 16'd4) begin
      bad++;
      $display("FAIL simul_s: result=%0d required 4", result);
    end
  endtask

  task automatic test_reset_mid();
    set_in(16'd5, 4'h8, 4'h0, 1, 0, 8'h00, 0); tick();
    set_in(16'd3, 4'h8, 4'h0, 0, 1, 8'h00, 0); tick();
    set_in(16'd0, 4'h8, 4'h0, 0, 0, 8'h08, 1);
    #2;
    reset = 1'b0;
    model_clear();
    tick();
    total++;
    if (result_valid !== 1'b0 || result !== 16'h0) begin
      bad++;
      $display("FAIL rstmid_pulse: result=%h valid=%b required 0000/0", result, result_valid);
    end
    reset = 1'b1;
    set_in(16'h0, 4'h3, 4'h0, 0, 0, 8'h00, 0);
    total++;
    if (bus !== 16'h0) begin
      bad++;
      $display("FAIL rstmid_r3: bus=%h required 0000", bus);
    end
    tick();
    set_in(16'h0, 4'h8, 4'h0, 0, 0, 8'h01, 0); tick();
    total++;
    if (result !== 16'h0 || result_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_c: result=%h valid=%b required 0000/0", result, result_valid);
    end
  endtask

  task automatic test_random();
    logic [7:0] e;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: e = 8'h00;
        1: e = 8'h01 << $urandom_range(0, 7);
        2: e = 8'($urandom);
        default: e = 8'h00;
      endcase
      set_in(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), e, 1'($urandom));
      total++;
      if (bus !== model_bus()) begin
        bad++;
        $display("FAIL rand_bus[%0d]: bus=%h required %h", n, bus, model_bus());
      end
      tick();
      total++;
      if (result !== m_result || result_valid !== m_rv) begin
        bad++;
        $display("FAIL rand_out[%0d]: result=%h valid=%b required %h/%b",
                 n, result, result_valid, m_result, m_rv);
      end
`ifdef CPU_DP_FLAGS_EN
      total++;
      if (flag_z !== m_fz || flag_c !== m_fc) begin
        bad++;
        $display("FAIL rand_flags[%0d]: z=%b c=%b required %b/%b", n, flag_z, flag_c, m_fz, m_fc);
      end
`endif
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_add_writeback();
    test_wrap();
    test_sub_underflow();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
